// File: rtl/lsu_data_mem_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store data memory:
//   - funct3 access-size encodings (SIZE_*)
//   - FSM state encoding (IDLE, BUSY)
//   - size_legal(): recognises the five supported access sizes
//   - ext_load(): sign/zero extension of the raw little-endian read bytes
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] SIZE_B  = 3'b000;
    localparam logic [2:0] SIZE_H  = 3'b001;
    localparam logic [2:0] SIZE_W  = 3'b010;
    localparam logic [2:0] SIZE_BU = 3'b100;
    localparam logic [2:0] SIZE_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic logic size_legal(input logic [2:0] size);
        return (size == SIZE_B)  || (size == SIZE_H) || (size == SIZE_W) ||
               (size == SIZE_BU) || (size == SIZE_HU);
    endfunction

    // bytes[7:0] is the byte at the access address, bytes[15:8] the next, etc.
    function automatic logic [31:0] ext_load(input logic [2:0] size, input logic [31:0] bytes);
        case (size)
            SIZE_B:  return {{24{bytes[7]}}, bytes[7:0]};
            SIZE_H:  return {{16{bytes[15]}}, bytes[15:0]};
            SIZE_W:  return bytes;
            SIZE_BU: return {24'h0, bytes[7:0]};
            SIZE_HU: return {16'h0, bytes[15:0]};
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_data_mem_if.sv
// -----------------------------------------------------------------------------
// lsu_data_mem_if
// req/gnt/rvalid bus between the core's load/store path and the data memory.
//   req_i, we_i, size_i, addr_i, wdata_i : request side (core -> memory)
//   gnt_o, rvalid_o, rdata_o, err_o      : response side (memory -> core)
// Modports: master = core, slave = memory.
// -----------------------------------------------------------------------------
interface lsu_data_mem_if;
    logic        req_i;
    logic        we_i;
    logic [2:0]  size_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, we_i, size_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, size_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/lsu_data_mem_byte_ram.sv
// -----------------------------------------------------------------------------
// byte_ram
// DEPTH_BYTES x 8 storage with a 4-lane byte write port and a combinational
// 4-byte read port, both based at addr.
//   clk    : rising-edge clock
//   we     : lane write enables; lane k writes mem[addr+k] from wdata[8k+7:8k]
//   addr   : base byte address
//   wdata  : lane-aligned write data
//   rdata  : mem[addr+3..addr] (little-endian; lanes past the end wrap and are
//            only ever consumed by accesses that the caller has already faulted)
// -----------------------------------------------------------------------------
module byte_ram #(
    parameter int DEPTH_BYTES = 1024,
    localparam int AW         = $clog2(DEPTH_BYTES)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [7:0] mem [DEPTH_BYTES];

    // NOTE: the array has no reset; a reset would turn it into flops instead of RAM.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we[k]) begin
                mem[addr + AW'(k)] <= wdata[8*k +: 8];
            end
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_rd
        assign rdata[8*k +: 8] = mem[addr + AW'(k)];
    end

endmodule

// File: rtl/lsu_data_mem.sv
// -----------------------------------------------------------------------------
// lsu_data_mem
// Byte-addressable data memory behind a req/gnt/rvalid handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lsu_data_mem_if.slave (req/we/size/addr/wdata in,
//                gnt/rvalid/rdata/err out)
// An access is accepted on the clock edge where gnt_o && req_i. Stores commit
// and loads sample the RAM at that edge; the response (rvalid_o pulse with
// rdata_o/err_o) appears LATENCY cycles later. Faulting accesses write nothing
// and answer with err_o=1, rdata_o=0.
// -----------------------------------------------------------------------------
module lsu_data_mem
    import lsu_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    lsu_data_mem_if.slave bus
);

    localparam int AW = $clog2(DEPTH_BYTES);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] pend_data_q, pend_data_d;   // response captured at accept
    logic        pend_err_q, pend_err_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept;
    logic        fault;
    logic [3:0]  ram_we;
    logic [31:0] ram_rdata;
    logic [31:0] resp_data;

    byte_ram #(.DEPTH_BYTES(DEPTH_BYTES)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (bus.addr_i[AW-1:0]),
        .wdata (bus.wdata_i),
        .rdata (ram_rdata)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        accept = (state_q == IDLE) && bus.req_i;

        // Range check spans all 32 address bits so high addresses never alias.
        fault = !size_legal(bus.size_i)
              || (((bus.size_i == SIZE_H) || (bus.size_i == SIZE_HU)) && bus.addr_i[0])
              || ((bus.size_i == SIZE_W) && (|bus.addr_i[1:0]))
              || (bus.addr_i >= 32'(DEPTH_BYTES));

        ram_we = 4'b0000;
        if (accept && bus.we_i && !fault) begin
            case (bus.size_i)
                SIZE_B:  ram_we = 4'b0001;
                SIZE_H:  ram_we = 4'b0011;
                SIZE_W:  ram_we = 4'b1111;
                default: ram_we = 4'b0000;
            endcase
        end

        resp_data = (fault || bus.we_i) ? 32'h0 : ext_load(bus.size_i, ram_rdata);

        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_data_d = pend_data_q;
        pend_err_d  = pend_err_q;
        rvalid_d    = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = BUSY;
                    cnt_d       = 2'(LATENCY - 1);
                    pend_data_d = resp_data;
                    pend_err_d  = fault;
                    // With LATENCY=1 the response cycle is the one right after accept.
                    if (LATENCY == 1) begin
                        rvalid_d = 1'b1;
                        rdata_d  = resp_data;
                        err_d    = fault;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                    // Outputs are registered, so load them on the edge entering cnt==0.
                    if (cnt_q == 2'd1) begin
                        rvalid_d = 1'b1;
                        rdata_d  = pend_data_q;
                        err_d    = pend_err_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            pend_data_q <= 32'h0;
            pend_err_q  <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_data_q <= pend_data_d;
            pend_err_q  <= pend_err_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign bus.gnt_o    = (state_q == IDLE);
    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = rdata_q;
    assign bus.err_o    = err_q;

endmodule

// File: tb/tb_lsu_data_mem.sv
// -----------------------------------------------------------------------------
// tb_lsu_data_mem
// Directed self-checking bench for lsu_data_mem (DEPTH_BYTES=1024, LATENCY=3).
// Inputs change just after rising edges; outputs are sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_lsu_data_mem;
    import lsu_pkg::*;

    localparam int DEPTH = 1024;
    localparam int LAT   = 3;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    lsu_data_mem_if bus ();

    lsu_data_mem #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One complete access: request at a falling edge, wait for grant, drop req
    // after the accept edge, then wait for rvalid. lat = falling edges from
    // accept to the rvalid cycle; 0 signals a timeout.
    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat);
        int waited;
        @(negedge clk);
        bus.req_i   = 1'b1;
        bus.we_i    = we;
        bus.size_i  = size;
        bus.addr_i  = addr;
        bus.wdata_i = wdata;
        waited = 0;
        while (!bus.gnt_o && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1 bus.req_i = 1'b0;
        lat = 0;
        rdata = 32'hx;
        err = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.rvalid_o) begin
                lat   = c;
                rdata = bus.rdata_o;
                err   = bus.err_o;
                break;
            end
        end
        if (lat == 0) $display("FAIL timeout: no rvalid for addr 0x%08h", addr);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] seq_addr [4];
    logic [31:0] seq_exp  [3];
    int          gnt_at   [3];
    int          n_gnt;
    int          n_rv;

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.size_i  = SIZE_W;
        bus.addr_i  = 32'h0;
        bus.wdata_i = 32'h0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rvalid", 32'(bus.rvalid_o), 32'd0);
        check("rst_rdata",  bus.rdata_o,       32'h0);
        check("rst_err",    32'(bus.err_o),    32'd0);
        check("rst_gnt",    32'(bus.gnt_o),    32'd1);
        rst_n = 1'b1;

        // 1. Word store/load and response latency
        access(1'b1, SIZE_W, 32'h10, 32'hDEADBEEF, rd, er, lat);
        check("sw_rdata", rd, 32'h0);
        check("sw_err",   32'(er), 32'd0);
        check("sw_lat",   32'(lat), 32'(LAT));
        access(1'b0, SIZE_W, 32'h10, 32'h0, rd, er, lat);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_err",   32'(er), 32'd0);
        check("lw_lat",   32'(lat), 32'(LAT));

        // 2. Byte/half lanes and extension
        access(1'b1, SIZE_W, 32'h20, 32'h11223344, rd, er, lat);
        access(1'b1, SIZE_B, 32'h21, 32'hAAAAAA80, rd, er, lat);
        access(1'b0, SIZE_B,  32'h21, 32'h0, rd, er, lat);
        check("lb_sext",  rd, 32'hFFFFFF80);
        access(1'b0, SIZE_BU, 32'h21, 32'h0, rd, er, lat);
        check("lbu_zext", rd, 32'h00000080);
        access(1'b0, SIZE_HU, 32'h20, 32'h0, rd, er, lat);
        check("lhu_20",   rd, 32'h00008044);
        access(1'b1, SIZE_H, 32'h22, 32'h55558001, rd, er, lat);
        access(1'b0, SIZE_H,  32'h22, 32'h0, rd, er, lat);
        check("lh_sext",  rd, 32'hFFFF8001);
        access(1'b0, SIZE_HU, 32'h22, 32'h0, rd, er, lat);
        check("lhu_zext", rd, 32'h00008001);
        access(1'b0, SIZE_W,  32'h20, 32'h0, rd, er, lat);
        check("lw_20",    rd, 32'h80018044);

        // 3. Misaligned accesses fault and leave memory alone
        access(1'b0, SIZE_H, 32'h11, 32'h0, rd, er, lat);
        check("lh_mis_err",   32'(er), 32'd1);
        check("lh_mis_rdata", rd, 32'h0);
        check("lh_mis_lat",   32'(lat), 32'(LAT));
        access(1'b1, SIZE_W, 32'h12, 32'h01020304, rd, er, lat);
        check("sw_mis_err",   32'(er), 32'd1);
        check("sw_mis_rdata", rd, 32'h0);
        access(1'b1, SIZE_HU, 32'h13, 32'h0000FFFF, rd, er, lat);
        check("shu_err",      32'(er), 32'd1);
        access(1'b0, SIZE_W, 32'h10, 32'h0, rd, er, lat);
        check("lw_unmod",     rd, 32'hDEADBEEF);

        // 4. Range and size faults
        access(1'b0, SIZE_W, 32'(DEPTH), 32'h0, rd, er, lat);
        check("oor_depth_err", 32'(er), 32'd1);
        access(1'b0, SIZE_W, 32'hFFFFFFFC, 32'h0, rd, er, lat);
        check("oor_high_err",  32'(er), 32'd1);
        check("oor_high_rd",   rd, 32'h0);
        access(1'b1, SIZE_W, 32'(DEPTH - 4), 32'hCAFEF00D, rd, er, lat);
        check("sw_top_err",    32'(er), 32'd0);
        access(1'b0, SIZE_W, 32'(DEPTH - 4), 32'h0, rd, er, lat);
        check("lw_top_err",    32'(er), 32'd0);
        check("lw_top_rdata",  rd, 32'hCAFEF00D);
        access(1'b0, SIZE_BU, 32'(DEPTH - 1), 32'h0, rd, er, lat);
        check("lbu_last",      rd, 32'h000000CA);
        access(1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
        check("size011_err",   32'(er), 32'd1);
        access(1'b0, SIZE_W, 32'h0, 32'h0, rd, er, lat);
        check("addr0_err",     32'(er), 32'd0);

        // 5. req_i held high: one accept per LAT+1 cycles, responses in order
        access(1'b1, SIZE_W, 32'h40, 32'h0A0A0A0A, rd, er, lat);
        access(1'b1, SIZE_W, 32'h44, 32'h0B0B0B0B, rd, er, lat);
        access(1'b1, SIZE_W, 32'h48, 32'h0C0C0C0C, rd, er, lat);
        seq_addr[0] = 32'h40; seq_addr[1] = 32'h44; seq_addr[2] = 32'h48; seq_addr[3] = 32'h10;
        seq_exp[0]  = 32'h0A0A0A0A; seq_exp[1] = 32'h0B0B0B0B; seq_exp[2] = 32'h0C0C0C0C;
        @(negedge clk);
        n_gnt = 0;
        n_rv  = 0;
        bus.req_i  = 1'b1;
        bus.we_i   = 1'b0;
        bus.size_i = SIZE_W;
        bus.addr_i = seq_addr[0];
        for (int c = 0; c < 3 * (LAT + 1); c++) begin
            logic g;
            g = bus.gnt_o;
            if (bus.rvalid_o) begin
                if (n_rv < 3) check("stream_rdata", bus.rdata_o, seq_exp[n_rv]);
                n_rv++;
            end
            @(posedge clk);
            #1;
            if (g) begin
                if (n_gnt < 3) gnt_at[n_gnt] = c;
                n_gnt++;
                bus.addr_i = seq_addr[(n_gnt < 4) ? n_gnt : 3];
            end
            @(negedge clk);
        end
        bus.req_i = 1'b0;
        check("stream_n_gnt", 32'(n_gnt), 32'd3);
        check("stream_n_rv",  32'(n_rv),  32'd3);
        check("stream_gap01", 32'(gnt_at[1] - gnt_at[0]), 32'(LAT + 1));
        check("stream_gap12", 32'(gnt_at[2] - gnt_at[1]), 32'(LAT + 1));

        // 6. Reset during BUSY drops the response, keeps the committed store
        @(negedge clk);
        bus.req_i   = 1'b1;
        bus.we_i    = 1'b1;
        bus.size_i  = SIZE_W;
        bus.addr_i  = 32'h80;
        bus.wdata_i = 32'h12345678;
        @(posedge clk);
        #1 bus.req_i = 1'b0;
        repeat (LAT) @(negedge clk);
        check("pre_rst_rvalid", 32'(bus.rvalid_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rvalid", 32'(bus.rvalid_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_gnt",   32'(bus.gnt_o), 32'd1);
        access(1'b0, SIZE_W, 32'h80, 32'h0, rd, er, lat);
        check("post_rst_lw",    rd, 32'h12345678);
        check("post_rst_err",   32'(er), 32'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
